// File: rtl/pfmonitor_stride.sv
// Stride prefetch monitor: trains a direct-mapped stride table on retired loads and
// emits DEGREE prefetch addresses per trigger. Optional counters under PFMON_STATS_EN.
module pfmonitor_stride #(
  parameter int PC_W       = 48,
  parameter int ADDR_W     = 50,
  parameter int ENTRIES    = 16,
  parameter int STRIDE_W   = 12,
  parameter int CONF_TH    = 2,
  parameter int DEGREE     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pfretire_valid,
  output logic              pfretire_retry,
  input  logic [PC_W-1:0]   pfretire_pc,
  input  logic [ADDR_W-1:0] pfretire_addr,
  input  logic              pfflush,
  output logic              pfpred_valid,
  input  logic              pfpred_retry,
  output logic [ADDR_W-1:0] pfpred_addr
`ifdef PFMON_STATS_EN
  ,
  output logic [15:0]       stat_retires,
  output logic [15:0]       stat_triggers,
  output logic [15:0]       stat_preds
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int K_W   = $clog2(DEGREE + 1);

  function automatic logic fits_stride(input logic signed [ADDR_W-1:0] d);
    logic signed [STRIDE_W-1:0] lo;
    lo = d[STRIDE_W-1:0];
    return (ADDR_W'(lo) == d);
  endfunction

  function automatic logic [ADDR_W-1:0] sext_stride(input logic signed [STRIDE_W-1:0] s);
    return ADDR_W'(s);
  endfunction

  function automatic logic [1:0] sat_conf(input logic [1:0] c);
    return (c == 2'd3) ? 2'd3 : c + 2'd1;
  endfunction

  typedef enum logic {IDLE, GEN} state_t;

  logic [ENTRIES-1:0]         tab_valid;
  logic [TAG_W-1:0]           tab_tag    [ENTRIES];
  logic [ADDR_W-1:0]          tab_last   [ENTRIES];
  logic signed [STRIDE_W-1:0] tab_stride [ENTRIES];
  logic [1:0]                 tab_conf   [ENTRIES];

  logic [IDX_W-1:0]           idx;
  logic [TAG_W-1:0]           tag;
  logic                       accept;
  logic                       hit;
  logic signed [ADDR_W-1:0]   delta;
  logic signed [STRIDE_W-1:0] new_stride;
  logic [1:0]                 new_conf;
  logic                       trigger;
  logic                       unused_pc;

  state_t                     state, state_nxt;
  logic [K_W-1:0]             gen_k;
  logic [ADDR_W-1:0]          gen_addr;
  logic [ADDR_W-1:0]          gen_stride;
  logic                       enq;
  logic                       deq;
  logic                       full;

  logic [ADDR_W-1:0]          fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]           rd_ptr, wr_ptr;
  logic [PTR_W:0]             count;

  assign idx       = pfretire_pc[IDX_W+1:2];
  assign tag       = pfretire_pc[PC_W-1:IDX_W+2];
  assign unused_pc = ^pfretire_pc[1:0];

  assign pfretire_retry = (state == GEN) | pfflush;
  assign accept         = pfretire_valid & ~pfretire_retry;
  assign hit            = tab_valid[idx] && (tab_tag[idx] == tag);
  assign delta          = pfretire_addr - tab_last[idx];

  // Training: next stride/confidence for the addressed entry
  always_comb begin
    new_stride = '0;
    new_conf   = '0;
    if (hit) begin
      if ((delta != '0) && fits_stride(delta) && (delta[STRIDE_W-1:0] == tab_stride[idx])) begin
        new_stride = tab_stride[idx];
        new_conf   = sat_conf(tab_conf[idx]);
      end else if (fits_stride(delta)) begin
        new_stride = delta[STRIDE_W-1:0];
      end
    end
  end

  assign trigger = accept & hit & (new_conf >= 2'(CONF_TH)) & (new_stride != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tab_valid <= '0;
    end else if (pfflush) begin
      tab_valid <= '0;
    end else if (accept) begin
      tab_valid[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      tab_tag[idx]    <= tag;
      tab_last[idx]   <= pfretire_addr;
      tab_stride[idx] <= new_stride;
      tab_conf[idx]   <= new_conf;
    end
  end

  // Generation: gen_addr always holds base + k*stride for the next enqueue
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      gen_k <= '0;
    end else begin
      state <= state_nxt;
      if (trigger) begin
        gen_k <= K_W'(1);
      end else if (enq) begin
        gen_k <= gen_k + K_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    enq       = 1'b0;
    case (state)
      IDLE: if (trigger) state_nxt = GEN;
      GEN: begin
        if (!full) begin
          enq = 1'b1;
          if (gen_k == K_W'(DEGREE)) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (trigger) begin
      gen_addr   <= pfretire_addr + sext_stride(new_stride);
      gen_stride <= sext_stride(new_stride);
    end else if (enq) begin
      gen_addr   <= gen_addr + gen_stride;
    end
  end

  // Prediction FIFO: full is judged on the registered count, so no bypass when full
  assign full         = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign pfpred_valid = (count != '0);
  assign deq          = pfpred_valid & ~pfpred_retry;
  assign pfpred_addr  = pfpred_valid ? fifo_mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) fifo_mem[wr_ptr] <= gen_addr;
  end

`ifdef PFMON_STATS_EN
  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_retires  <= '0;
      stat_triggers <= '0;
      stat_preds    <= '0;
    end else begin
      if (accept)  stat_retires  <= sat16(stat_retires);
      if (trigger) stat_triggers <= sat16(stat_triggers);
      if (deq)     stat_preds    <= sat16(stat_preds);
    end
  end
`endif

endmodule

// File: tb/tb_pfmonitor_stride.sv
// Directed bench for pfmonitor_stride (default build, stats disabled).
module tb_pfmonitor_stride;
  localparam int PC_W   = 48;
  localparam int ADDR_W = 50;

  logic              clk = 1'b0;
  logic              reset;
  logic              pfretire_valid;
  logic              pfretire_retry;
  logic [PC_W-1:0]   pfretire_pc;
  logic [ADDR_W-1:0] pfretire_addr;
  logic              pfflush;
  logic              pfpred_valid;
  logic              pfpred_retry;
  logic [ADDR_W-1:0] pfpred_addr;

  int n_chk = 0;
  int n_err = 0;

  pfmonitor_stride dut (
    .clk           (clk),
    .reset         (reset),
    .pfretire_valid(pfretire_valid),
    .pfretire_retry(pfretire_retry),
    .pfretire_pc   (pfretire_pc),
    .pfretire_addr (pfretire_addr),
    .pfflush       (pfflush),
    .pfpred_valid  (pfpred_valid),
    .pfpred_retry  (pfpred_retry),
    .pfpred_addr   (pfpred_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a retire and hold it until accepted (bounded)
  task automatic retire(input logic [PC_W-1:0] pc, input logic [ADDR_W-1:0] addr);
    int n;
    n = 0;
    pfretire_valid = 1'b1;
    pfretire_pc    = pc;
    pfretire_addr  = addr;
    #2;
    while (pfretire_retry && n < 20) begin
      tick();
      #2;
      n++;
    end
    chk("retire_accept", pfretire_retry, 0);
    tick();
    pfretire_valid = 1'b0;
  endtask

  // Called in cycle T+1 after a triggering retire, with pfpred_retry low
  task automatic expect_burst(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    #2;
    chk("burst_t1_retry", pfretire_retry, 1);
    chk("burst_t1_valid", pfpred_valid, 0);
    tick();
    #2;
    chk("burst_t2_retry", pfretire_retry, 1);
    chk("burst_t2_valid", pfpred_valid, 1);
    chk("burst_t2_addr", pfpred_addr, a0);
    tick();
    #2;
    chk("burst_t3_retry", pfretire_retry, 0);
    chk("burst_t3_valid", pfpred_valid, 1);
    chk("burst_t3_addr", pfpred_addr, a1);
    tick();
    #2;
    chk("burst_t4_valid", pfpred_valid, 0);
    tick();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      #2;
      chk("no_pred", pfpred_valid, 0);
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [ADDR_W-1:0] bp_exp [6];
    reset          = 1'b0;
    pfretire_valid = 1'b0;
    pfretire_pc    = '0;
    pfretire_addr  = '0;
    pfflush        = 1'b0;
    pfpred_retry   = 1'b0;
    #2;
    chk("rst_pred_valid", pfpred_valid, 0);
    chk("rst_pred_addr", pfpred_addr, 0);
    chk("rst_retire_retry", pfretire_retry, 0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Positive stride
    retire(48'h400, 50'h1000);
    retire(48'h400, 50'h1040);
    retire(48'h400, 50'h1080);
    #1;
    chk("train_no_pred", pfpred_valid, 0);
    #0;
    pfretire_valid = 1'b1;
    pfretire_pc    = 48'h400;
    pfretire_addr  = 50'h10C0;
    #1;
    chk("train_4th_accept", pfretire_retry, 0);
    tick();
    pfretire_valid = 1'b0;
    expect_burst(50'h1100, 50'h1140);

    // Negative stride
    retire(48'h800, 50'h2000);
    retire(48'h800, 50'h1FF8);
    retire(48'h800, 50'h1FF0);
    retire(48'h800, 50'h1FE8);
    expect_burst(50'h1FE0, 50'h1FD8);

    // Backpressure: three triggers while consumer stalls
    pfpred_retry = 1'b1;
    retire(48'h404, 50'h3000);
    retire(48'h404, 50'h3010);
    retire(48'h404, 50'h3020);
    retire(48'h404, 50'h3030);
    retire(48'h404, 50'h3040);
    retire(48'h404, 50'h3050);
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("bp_stall_retry", pfretire_retry, 1);
      chk("bp_stall_valid", pfpred_valid, 1);
      chk("bp_stall_head", pfpred_addr, 50'h3040);
      tick();
    end
    bp_exp[0] = 50'h3040; bp_exp[1] = 50'h3050; bp_exp[2] = 50'h3050;
    bp_exp[3] = 50'h3060; bp_exp[4] = 50'h3060; bp_exp[5] = 50'h3070;
    pfpred_retry = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #2;
      chk("bp_drain_valid", pfpred_valid, 1);
      chk("bp_drain_addr", pfpred_addr, bp_exp[i]);
      tick();
    end
    #2;
    chk("bp_drained", pfpred_valid, 0);
    chk("bp_retry_clear", pfretire_retry, 0);
    tick();

    // Stride break with out-of-range delta, then retrain
    retire(48'h408, 50'h5000);
    retire(48'h408, 50'h5020);
    retire(48'h408, 50'h5040);
    retire(48'h408, 50'h5060);
    expect_burst(50'h5080, 50'h50A0);
    retire(48'h408, 50'h45060);
    idle_cycles(2);
    retire(48'h408, 50'h45080);
    idle_cycles(1);
    retire(48'h408, 50'h450A0);
    idle_cycles(1);
    retire(48'h408, 50'h450C0);
    expect_burst(50'h450E0, 50'h45100);

    // Flush with simultaneous retire
    retire(48'h40C, 50'h6000);
    retire(48'h40C, 50'h6008);
    retire(48'h40C, 50'h6010);
    pfretire_valid = 1'b1;
    pfretire_pc    = 48'h40C;
    pfretire_addr  = 50'h6018;
    pfflush        = 1'b1;
    #2;
    chk("flush_retry", pfretire_retry, 1);
    tick();
    pfflush        = 1'b0;
    pfretire_valid = 1'b0;
    retire(48'h40C, 50'h6018);
    idle_cycles(2);
    retire(48'h40C, 50'h6020);
    retire(48'h40C, 50'h6028);
    idle_cycles(2);

    // Alias: same index, different tags
    for (int i = 0; i < 4; i++) begin
      retire(48'h410, 50'h8000 + 50'(i * 16));
      retire(48'h450, 50'h9000 + 50'(i * 16));
    end
    idle_cycles(3);

    // Reset during generation with two entries queued
    pfpred_retry = 1'b1;
    retire(48'h414, 50'h7000);
    retire(48'h414, 50'h7100);
    retire(48'h414, 50'h7200);
    retire(48'h414, 50'h7300);
    retire(48'h414, 50'h7400);
    #1;
    chk("midgen_retry", pfretire_retry, 1);
    chk("midgen_fifo", pfpred_valid, 1);
    reset = 1'b0;
    #1;
    chk("rst_midgen_valid", pfpred_valid, 0);
    chk("rst_midgen_retry", pfretire_retry, 0);
    chk("rst_midgen_addr", pfpred_addr, 0);
    tick();
    reset        = 1'b1;
    pfpred_retry = 1'b0;
    retire(48'h414, 50'h7500);
    idle_cycles(3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/pfmonitor_stride.md
Name: pfmonitor_stride

Overview:
- Parametrised successor to the prefetch monitor.
- Observes retired load PCs and addresses and trains a direct-mapped stride table.
- When an entry reaches confidence, a generator FSM issues DEGREE prefetch addresses into an output FIFO toward the L1/L2 prefetch path.
- Sits between core retire and the prefetch request interface; uses valid/retry handshakes throughout.

Parameters:
PC_W, 48, retired load PC width
ADDR_W, 50, byte address width
ENTRIES, 16, stride table entries (power of 2, >=2); IDX_W=log2(ENTRIES)
STRIDE_W, 12, signed stride width
CONF_TH, 2, confidence at or above which a trigger fires (1..3)
DEGREE, 2, predictions per trigger (1..8)
FIFO_DEPTH, 4, prediction FIFO entries (power of 2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (low = reset)
pfretire_valid  in  1  retired load present
pfretire_retry  out  1  retire not accepted this cycle
pfretire_pc  in  PC_W  load PC
pfretire_addr  in  ADDR_W  load address
pfflush  in  1  one-cycle pulse: invalidate whole table
pfpred_valid  out  1  prediction available
pfpred_retry  in  1  consumer not ready
pfpred_addr  out  ADDR_W  predicted prefetch address

Behaviour:
- Reset (async, on reset low):
  - All table valids = 0; FIFO empty; FSM = IDLE.
  - pfpred_valid = 0, pfpred_addr = 0, pfretire_retry = 0.
  - Asserting reset mid-GEN aborts generation; no partial state survives.
- Handshakes:
  - Retire accepted when pfretire_valid && !pfretire_retry.
  - pfretire_retry = (FSM == GEN) | pfflush.
  - Prediction consumed when pfpred_valid && !pfpred_retry.
- Table indexing:
  - Index = pc[IDX_W+1:2].
  - Tag = pc[PC_W-1:IDX_W+2].
  - Entry = {valid, tag, last_addr[ADDR_W], stride[STRIDE_W] signed, conf[2]}.
- Training, applied at the edge ending the accept cycle:
  - Miss (invalid or tag mismatch): allocate with valid=1, tag, last_addr=addr, stride=0, conf=0. No trigger.
  - Hit: delta = addr - last_addr, computed modulo 2^ADDR_W and interpreted as signed.
    - If delta is nonzero, fits STRIDE_W signed, and equals stride: conf = min(conf+1, 3).
    - Else if delta fits STRIDE_W: stride = delta, conf = 0.
    - Else (out of range): stride = 0, conf = 0.
    - last_addr = addr in all hit cases.
  - Trigger when post-update conf >= CONF_TH and stride != 0. On trigger, latch base=addr and stride, set k=1, and enter GEN.
- FSM:
  - IDLE -> GEN on trigger.
  - In GEN, each cycle the FIFO is not full, enqueue base + k*stride (sign-extended, modulo 2^ADDR_W) and increment k.
  - GEN -> IDLE after enqueuing k == DEGREE.
  - GEN stalls while the FIFO is full; predictions are never dropped.
- FIFO:
  - Enqueue is checked against the full flag at the start of the cycle; no same-cycle bypass of a full FIFO.
  - Dequeue and enqueue may occur in the same cycle when not full.
  - pfpred_addr = head entry. It holds stable while pfpred_valid && pfpred_retry.
- Latency: retire accepted in cycle T -> first prediction enqueued at edge end of T+1 -> pfpred_valid high in T+2.
  - Subsequent predictions follow one per cycle when the FIFO has space.
- Flush:
  - pfflush clears all table valids at the next edge.
  - A retire in the same cycle is retried, not recorded.
  - An in-progress GEN and the FIFO contents are unaffected.
- Wrap: address arithmetic wraps modulo 2^ADDR_W; no page-boundary filtering.

Optional Feature:
- Macro: PFMON_STATS_EN.
- When defined, the block adds outputs stat_retires, stat_triggers, stat_preds (16 bits each, saturating at 0xFFFF).
  - Each counts accepted retires, triggers, and dequeued predictions respectively.
  - All reset to 0.
- When not defined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Stride train (defaults): pc 0x400, addrs 0x1000, 0x1040, 0x1080, 0x10C0 back-to-back -> first three produce no predictions; after 0x10C0, pfpred_addr 0x1100 then 0x1140; pfretire_retry high for exactly 2 cycles.
- Negative stride: pc 0x800, addrs 0x2000, 0x1FF8, 0x1FF0, 0x1FE8 -> predictions 0x1FE0, 0x1FD8.
- Backpressure: hold pfpred_retry=1, run 3 triggers -> FIFO fills at 4; GEN stalls and pfretire_retry stays high; release retry -> all 6 addresses emerge in order, none lost.
- Stride break / out of range: trained pc, then delta 0x40000 -> stride=0, conf=0, no prediction; the following 3 equal deltas retrain and trigger again.
- Flush and alias: after training, pulse pfflush with a simultaneous retire -> retire retried; the next retire of the same pc allocates fresh (no trigger). Two PCs with the same index and different tags evict each other; neither triggers.
- Reset mid-GEN: assert reset while GEN and FIFO hold 2 entries -> pfpred_valid=0 and pfretire_retry=0 immediately; table empty after release.
